ex_stage: RTL and testbench

- Execute stage of the 5-stage pipeline. It sits directly downstream of the forwarding unit and consumes its forwardA/forwardB selects.
- Selects forwarded operands, performs the ALU operation (single-cycle ops plus an iterative 32-cycle MUL), and owns the EX/MEM pipeline register.
- Generates a stall request while a multiply is in flight. Honours a downstream memory stall and a branch flush.

---
 rtl/ex_stage.sv | 217 +++++++++++++++++++++
 tb/tb_ex_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
//   Selects forwarded operands, runs the ALU (single-cycle ops plus an
//   iterative shift-add MUL) and owns the EX/MEM pipeline register.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   id_ex_*                     live ID/EX instruction: operands, op, rd, control bits
//   forwardA/forwardB           operand forwarding selects (10: EX/MEM, 01: MEM/WB)
//   ex_mem_fwd_data, mem_wb_fwd_data  forwarding sources
//   mem_stall, ex_flush         downstream hold and kill of the EX instruction
//   ex_stall_req                upstream must hold ID/EX
//   ex_mem_*                    EX/MEM register contents
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_ex_valid,
  input  logic [XLEN-1:0] id_ex_rs_data,
  input  logic [XLEN-1:0] id_ex_rt_data,
  input  logic [XLEN-1:0] id_ex_imm,
  input  logic [3:0]      id_ex_alu_op,
  input  logic            id_ex_alu_src,
  input  logic [4:0]      id_ex_rd,
  input  logic            id_ex_regWrite,
  input  logic            id_ex_memRead,
  input  logic            id_ex_memWrite,
  input  logic            id_ex_memToReg,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] ex_mem_fwd_data,
  input  logic [XLEN-1:0] mem_wb_fwd_data,
  input  logic            mem_stall,
  input  logic            ex_flush,
  output logic            ex_stall_req,
  output logic            ex_mem_valid,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_store_data,
  output logic [4:0]      ex_mem_rd,
  output logic            ex_mem_regWrite,
  output logic            ex_mem_memRead,
  output logic            ex_mem_memWrite,
  output logic            ex_mem_memToReg
);

  localparam logic [3:0]    OP_MUL = 4'd12;
  localparam int            CW     = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] LAST   = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                              input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] exm,
                                              input logic [XLEN-1:0] mwb);
    case (sel)
      2'b10:   return exm;
      2'b01:   return mwb;
      default: return rf;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [4:0]             sh;
    sa = a;
    sb = b;
    sh = b[4:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return {{(XLEN-1){1'b0}}, (sa < sb)};
      4'd7:    return {{(XLEN-1){1'b0}}, (a < b)};
      4'd8:    return a << sh;
      4'd9:    return a >> sh;
      4'd10:   return $unsigned(sa >>> sh);
      4'd11:   return b << 16;
      default: return '0;  // MUL is produced by the iterative unit; 13-15 yield 0
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_acc_q, mul_acc_d;
  logic [XLEN-1:0] hold_store_q, hold_store_d;
  logic [4:0]      hold_rd_q, hold_rd_d;
  logic [3:0]      hold_ctrl_q, hold_ctrl_d;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d, store_q, store_d;
  logic [4:0]      rd_q, rd_d;
  logic [3:0]      ctrl_q, ctrl_d;

  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res;
  logic [3:0]      id_ctrl;
  logic            mul_req;

  assign fwd_a   = fwd_mux(forwardA, id_ex_rs_data, ex_mem_fwd_data, mem_wb_fwd_data);
  assign fwd_b   = fwd_mux(forwardB, id_ex_rt_data, ex_mem_fwd_data, mem_wb_fwd_data);
  assign op_b    = id_ex_alu_src ? id_ex_imm : fwd_b;
  assign alu_res = alu_calc(id_ex_alu_op, fwd_a, op_b);
  assign id_ctrl = {id_ex_regWrite, id_ex_memRead, id_ex_memWrite, id_ex_memToReg};
  assign mul_req = (state_q == IDLE) && id_ex_valid && (id_ex_alu_op == OP_MUL);

  assign ex_stall_req = rst_n && (mem_stall || mul_req || (state_q == RUN));

  // Multiply sequencer: runs independently of mem_stall, only a flush cancels it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_acc_d    = mul_acc_q;
    hold_store_d = hold_store_q;
    hold_rd_d    = hold_rd_q;
    hold_ctrl_d  = hold_ctrl_q;
    case (state_q)
      IDLE: begin
        if (mul_req && !mem_stall && !ex_flush) begin
          mul_a_d      = fwd_a;
          mul_b_d      = fwd_b;
          mul_acc_d    = '0;
          cnt_d        = '0;
          hold_store_d = fwd_b;
          hold_rd_d    = id_ex_rd;
          hold_ctrl_d  = id_ctrl;
          state_d      = RUN;
        end
      end
      RUN: begin
        // Shift-add step: multiplier LSB selects whether the shifted multiplicand is added.
        if (mul_b_q[0]) mul_acc_d = mul_acc_q + mul_a_q;
        mul_a_d = mul_a_q << 1;
        mul_b_d = mul_b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (!mem_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ex_flush) state_d = IDLE;
  end

  // EX/MEM update: hold under mem_stall, bubble on flush or when nothing completes.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    store_d  = store_q;
    rd_d     = rd_q;
    ctrl_d   = ctrl_q;
    if (!mem_stall) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (!ex_flush) begin
        if (state_q == DONE) begin
          valid_d  = 1'b1;
          result_d = mul_acc_q;
          store_d  = hold_store_q;
          rd_d     = hold_rd_q;
          ctrl_d   = hold_ctrl_q;
        end else if ((state_q == IDLE) && id_ex_valid && (id_ex_alu_op != OP_MUL)) begin
          valid_d  = 1'b1;
          result_d = alu_res;
          store_d  = fwd_b;
          rd_d     = id_ex_rd;
          ctrl_d   = id_ctrl;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Multiplier datapath and held MUL metadata need no reset: only read after acceptance.
  always_ff @(posedge clk) begin
    mul_a_q      <= mul_a_d;
    mul_b_q      <= mul_b_d;
    mul_acc_q    <= mul_acc_d;
    hold_store_q <= hold_store_d;
    hold_rd_q    <= hold_rd_d;
    hold_ctrl_q  <= hold_ctrl_d;
  end

  assign ex_mem_valid      = valid_q;
  assign ex_mem_alu_result = result_q;
  assign ex_mem_store_data = store_q;
  assign ex_mem_rd         = rd_q;
  assign {ex_mem_regWrite, ex_mem_memRead, ex_mem_memWrite, ex_mem_memToReg} = ctrl_q;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_ex_valid;
  logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [3:0]  id_ex_alu_op;
  logic        id_ex_alu_src;
  logic [4:0]  id_ex_rd;
  logic        id_ex_regWrite, id_ex_memRead, id_ex_memWrite, id_ex_memToReg;
  logic [1:0]  forwardA, forwardB;
  logic [31:0] ex_mem_fwd_data, mem_wb_fwd_data;
  logic        mem_stall, ex_flush;
  logic        ex_stall_req, ex_mem_valid;
  logic [31:0] ex_mem_alu_result, ex_mem_store_data;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_regWrite, ex_mem_memRead, ex_mem_memWrite, ex_mem_memToReg;
  logic [3:0]  ctrl_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign ctrl_o = {ex_mem_regWrite, ex_mem_memRead, ex_mem_memWrite, ex_mem_memToReg};

  ex_stage #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_ex_valid(id_ex_valid),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
    .id_ex_alu_op(id_ex_alu_op), .id_ex_alu_src(id_ex_alu_src), .id_ex_rd(id_ex_rd),
    .id_ex_regWrite(id_ex_regWrite), .id_ex_memRead(id_ex_memRead),
    .id_ex_memWrite(id_ex_memWrite), .id_ex_memToReg(id_ex_memToReg),
    .forwardA(forwardA), .forwardB(forwardB),
    .ex_mem_fwd_data(ex_mem_fwd_data), .mem_wb_fwd_data(mem_wb_fwd_data),
    .mem_stall(mem_stall), .ex_flush(ex_flush), .ex_stall_req(ex_stall_req),
    .ex_mem_valid(ex_mem_valid), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_store_data(ex_mem_store_data), .ex_mem_rd(ex_mem_rd),
    .ex_mem_regWrite(ex_mem_regWrite), .ex_mem_memRead(ex_mem_memRead),
    .ex_mem_memWrite(ex_mem_memWrite), .ex_mem_memToReg(ex_mem_memToReg)
  );

  // Reference model: operand selection and ALU rules in plain arithmetic.
  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] exm, input logic [31:0] mwb);
    if (sel == 2'b10) return exm;
    if (sel == 2'b01) return mwb;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [63:0] p;
    sh = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return a << sh;
      4'd9:  return a >> sh;
      4'd10: return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd11: return b << 16;
      4'd12: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] imm, input logic src,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] exm,
                       input logic [31:0] mwb, input logic [4:0] rd, input logic [3:0] ctrl);
    id_ex_valid = v; id_ex_alu_op = op; id_ex_rs_data = rs; id_ex_rt_data = rt;
    id_ex_imm = imm; id_ex_alu_src = src; forwardA = fa; forwardB = fb;
    ex_mem_fwd_data = exm; mem_wb_fwd_data = mwb; id_ex_rd = rd;
    {id_ex_regWrite, id_ex_memRead, id_ex_memWrite, id_ex_memToReg} = ctrl;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_stall = 1'b0; ex_flush = 1'b0;
    drive(1'b1, 4'd12, 32'd3, 32'd4, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd1, 4'hF);
    #1;
    vectors++;
    if (ex_stall_req !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall: got %b expected 0", ex_stall_req);
    end
    tick; tick;
    vectors++;
    if ({ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ctrl_o} !== 74'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b res=%h st=%h rd=%0d ctrl=%b expected all 0",
               ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ctrl_o);
    end
    id_ex_valid = 1'b0;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_directed;
    logic [3:0]  opv [8];
    logic [1:0]  fav [8], fbv [8];
    logic [31:0] rsv [8], rtv [8], immv [8], exv [8], mwv [8], resv [8], stv [8];
    logic        srcv [8];
    opv  = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd10, 4'd0, 4'd11, 4'd14};
    fav  = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
    fbv  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    rsv  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h100, 32'd9, 32'd5};
    rtv  = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd4, 32'd0, 32'd6, 32'd7};
    immv = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd8, 32'h1234, 32'd0};
    srcv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exv  = '{32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'hDEAD, 32'd0, 32'd0};
    mwv  = '{32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    resv = '{32'd12, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hF8000000, 32'h108, 32'h12340000, 32'd0};
    stv  = '{32'd7, 32'd1, 32'd1, 32'd1, 32'd4, 32'hDEAD, 32'd6, 32'd7};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, opv[i], rsv[i], rtv[i], immv[i], srcv[i], fav[i], fbv[i], exv[i], mwv[i],
            5'(i + 3), 4'b1001);
      tick;
      vectors++;
      if ({ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ctrl_o} !==
          {1'b1, resv[i], stv[i], 5'(i + 3), 4'b1001}) begin
        miscompares++;
        $display("FAIL directed_%0d: got v=%b res=%h st=%h rd=%0d ctrl=%b expected res=%h st=%h",
                 i, ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ctrl_o,
                 resv[i], stv[i]);
      end
    end
    id_ex_valid = 1'b0;
    tick;
    vectors++;
    if ({ex_mem_valid, ctrl_o} !== 5'd0) begin
      miscompares++; $display("FAIL idle_bubble: got v=%b ctrl=%b expected 0", ex_mem_valid, ctrl_o);
    end
  endtask

  task automatic test_alu_random(input int n);
    logic [3:0] op, ctrl; logic [1:0] fa, fb; logic src; logic [4:0] rd;
    logic [31:0] rs, rt, imm, exm, mwb, a, bf, exp;
    for (int i = 0; i < n; i++) begin
      op = 4'($urandom_range(0, 14));
      if (op >= 4'd12) op = op + 4'd1;
      fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
      src = 1'($urandom_range(0, 1)); rd = 5'($urandom_range(0, 31));
      ctrl = 4'($urandom_range(0, 15));
      rs = $urandom; rt = $urandom; imm = $urandom; exm = $urandom; mwb = $urandom;
      a  = ref_fwd(fa, rs, exm, mwb);
      bf = ref_fwd(fb, rt, exm, mwb);
      exp = ref_alu(op, a, src ? imm : bf);
      drive(1'b1, op, rs, rt, imm, src, fa, fb, exm, mwb, rd, ctrl);
      tick;
      vectors++;
      if ({ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ctrl_o} !==
          {1'b1, exp, bf, rd, ctrl}) begin
        miscompares++;
        $display("FAIL alu_rand op=%0d: got v=%b res=%h st=%h rd=%0d ctrl=%b expected res=%h st=%h rd=%0d ctrl=%b",
                 op, ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ctrl_o,
                 exp, bf, rd, ctrl);
      end
    end
    id_ex_valid = 1'b0;
    tick;
  endtask

  task automatic test_mul(input logic [31:0] rs, input logic [31:0] rt, input logic [1:0] fa,
                          input logic [1:0] fb, input logic with_stall);
    logic [31:0] exm, mwb, exp; logic [4:0] rd; logic [3:0] ctrl;
    int stall_cycles; int bubble_bad;
    exm = $urandom; mwb = $urandom;
    rd = 5'($urandom_range(1, 31)); ctrl = 4'($urandom_range(0, 15));
    exp = ref_alu(4'd12, ref_fwd(fa, rs, exm, mwb), ref_fwd(fb, rt, exm, mwb));
    drive(1'b1, 4'd12, rs, rt, 32'd0, 1'b0, fa, fb, exm, mwb, rd, ctrl);
    #1;
    stall_cycles = ex_stall_req ? 1 : 0;
    bubble_bad = 0;
    for (int k = 1; k <= 34; k++) begin
      tick;
      if (k == 34) begin
        vectors++;
        if ({ex_mem_valid, ex_mem_alu_result, ex_mem_rd, ctrl_o} !== {1'b1, exp, rd, ctrl}) begin
          miscompares++;
          $display("FAIL mul_result: got v=%b res=%h rd=%0d ctrl=%b expected v=1 res=%h rd=%0d ctrl=%b",
                   ex_mem_valid, ex_mem_alu_result, ex_mem_rd, ctrl_o, exp, rd, ctrl);
        end
        id_ex_valid = 1'b0;
      end else begin
        if ({ex_mem_valid, ctrl_o} !== 5'd0) bubble_bad++;
        // Forwarding sources change while the multiply runs; the product must not.
        ex_mem_fwd_data = $urandom; mem_wb_fwd_data = $urandom;
        mem_stall = with_stall && (k >= 5) && (k <= 7);
        #1;
        if (ex_stall_req) stall_cycles++;
      end
    end
    vectors++;
    if (stall_cycles !== 33) begin
      miscompares++; $display("FAIL mul_stall_cycles: got %0d expected 33", stall_cycles);
    end
    vectors++;
    if (bubble_bad !== 0) begin
      miscompares++; $display("FAIL mul_bubbles: got %0d non-bubble cycles expected 0", bubble_bad);
    end
    tick;
  endtask

  task automatic test_mul_flush;
    int seen;
    drive(1'b1, 4'd12, 32'd3, 32'd5, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd4, 4'b1000);
    for (int k = 0; k < 6; k++) tick;
    ex_flush = 1'b1; id_ex_valid = 1'b0;
    tick;
    ex_flush = 1'b0;
    #1;
    vectors++;
    if ({ex_stall_req, ex_mem_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_mul: got stall=%b v=%b expected 0 0", ex_stall_req, ex_mem_valid);
    end
    drive(1'b1, 4'd0, 32'd10, 32'd20, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd6, 4'b1000);
    tick;
    vectors++;
    if ({ex_mem_valid, ex_mem_alu_result, ex_mem_rd} !== {1'b1, 32'd30, 5'd6}) begin
      miscompares++;
      $display("FAIL flush_then_add: got v=%b res=%h rd=%0d expected 1 0000001e 6",
               ex_mem_valid, ex_mem_alu_result, ex_mem_rd);
    end
    id_ex_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (ex_mem_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++; $display("FAIL flush_no_product: got %0d valid writes expected 0", seen);
    end
  endtask

  task automatic test_stall_flush;
    drive(1'b1, 4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd9, 4'b1000);
    tick;
    drive(1'b1, 4'd4, 32'h55, 32'hAA, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd10, 4'b1000);
    mem_stall = 1'b1; ex_flush = 1'b1;
    tick;
    #1;
    vectors++;
    if ({ex_stall_req, ex_mem_valid, ex_mem_alu_result, ex_mem_rd} !== {1'b1, 1'b1, 32'd3, 5'd9}) begin
      miscompares++;
      $display("FAIL stall_flush_hold1: got stall=%b v=%b res=%h rd=%0d expected 1 1 00000003 9",
               ex_stall_req, ex_mem_valid, ex_mem_alu_result, ex_mem_rd);
    end
    ex_flush = 1'b0;
    tick;
    vectors++;
    if ({ex_mem_valid, ex_mem_alu_result} !== {1'b1, 32'd3}) begin
      miscompares++;
      $display("FAIL stall_hold2: got v=%b res=%h expected 1 00000003", ex_mem_valid, ex_mem_alu_result);
    end
    mem_stall = 1'b0;
    drive(1'b1, 4'd4, 32'hF0, 32'h0F, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd11, 4'b1000);
    tick;
    vectors++;
    if ({ex_mem_valid, ex_mem_alu_result, ex_mem_rd} !== {1'b1, 32'hFF, 5'd11}) begin
      miscompares++;
      $display("FAIL stall_release: got v=%b res=%h rd=%0d expected 1 000000ff 11",
               ex_mem_valid, ex_mem_alu_result, ex_mem_rd);
    end
    id_ex_valid = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_mul;
    drive(1'b1, 4'd12, 32'd7, 32'd9, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd2, 4'b1000);
    for (int k = 0; k < 10; k++) tick;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ex_stall_req !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_stall: got %b expected 0", ex_stall_req);
    end
    tick;
    vectors++;
    if ({ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ctrl_o} !== 74'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got v=%b res=%h st=%h rd=%0d ctrl=%b expected all 0",
               ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ctrl_o);
    end
    id_ex_valid = 1'b0;
    rst_n = 1'b1;
    tick;
    vectors++;
    if ({ex_stall_req, ex_mem_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid_idle: got stall=%b v=%b expected 0 0", ex_stall_req, ex_mem_valid);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_alu_random(60);
    test_mul(32'h10000, 32'h10001, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++)
      test_mul($urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1);
    test_mul_flush;
    test_stall_flush;
    test_reset_mid_mul;
    test_mul($urandom, $urandom, 2'b10, 2'b01, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
